// File: rtl/pc_flow_ctrl.sv
// pc_flow_ctrl: sequences the PC unit. Merges exception, execute redirect and
// interrupt into one jump triple, drives the pipeline hold bus, inserts
// post-redirect flush bubbles and runs the debug halt/resume handshake.
//
// Handshake: no valid/ready pairs here. Requests are level (irq_req_i,
// dbg_halt_req_i) or single-cycle (redirects, dbg_resume_req_i). Acknowledges
// are irq_ack_o (one cycle) and dbg_halted_o (level while halted).
module pc_flow_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int IRQ_ACK_W    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ex_redirect_valid_i,
   input  logic [2:0]        ex_redirect_cause_i,
   input  logic [ADDR_W-1:0] ex_redirect_from_i,
   input  logic [ADDR_W-1:0] ex_redirect_to_i,
   input  logic              exc_valid_i,
   input  logic [ADDR_W-1:0] exc_pc_i,
   input  logic [ADDR_W-1:0] exc_vector_i,
   input  logic              irq_req_i,
   input  logic              irq_en_i,
   input  logic [ADDR_W-1:0] irq_vector_i,
   input  logic [ADDR_W-1:0] irq_ret_pc_i,
   input  logic              mem_stall_i,
   input  logic              div_stall_i,
   input  logic              dbg_halt_req_i,
   input  logic              dbg_resume_req_i,
   output logic [2:0]        jump_cause_o,
   output logic [ADDR_W-1:0] jump_from_addr_o,
   output logic [ADDR_W-1:0] jump_to_addr_o,
   output logic [2:0]        hold_flag_o,
   output logic              flush_o,
   output logic              irq_ack_o,
   output logic              dbg_halted_o
);

   // Elaboration-time sanity on parameters this revision supports.
   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush
      $error("pc_flow_ctrl: FLUSH_CYCLES must be 1..7");
   end
   if (IRQ_ACK_W != 1) begin : g_bad_ack
      $error("pc_flow_ctrl: IRQ_ACK_W must be 1");
   end

   localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
   localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

   localparam logic [2:0] CAUSE_NONE = 3'd0;
   localparam logic [2:0] CAUSE_NOCOND = 3'd3;
   localparam logic [2:0] CAUSE_IRQ  = 3'd4;
   localparam logic [2:0] CAUSE_EXC  = 3'd5;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_FLUSH  = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_HALTED = 2'd3
   } state_t;

   state_t     state;
   logic [2:0] flush_cnt;
   logic       irq_pending;

   logic       redirect_ok;
   logic       exc_take;
   logic       ex_take;
   logic       irq_take;
   logic       issued;
   logic       any_stall;
   logic [2:0] ex_cause;

   // Arbitration qualifiers; everything is masked while reset is held so the
   // outputs read zero during reset regardless of input activity.
   always_comb begin
      any_stall   = mem_stall_i | div_stall_i;
      redirect_ok = rst_n && (state != ST_HALTED);
      exc_take    = redirect_ok && exc_valid_i;
      ex_take     = redirect_ok && !exc_valid_i && ex_redirect_valid_i;
      irq_take    = rst_n && (state == ST_RUN) && !any_stall && !exc_valid_i &&
                    !ex_redirect_valid_i && irq_en_i && (irq_pending || irq_req_i);
      issued      = exc_take | ex_take | irq_take;
      ex_cause    = (ex_redirect_cause_i >= 3'd1 && ex_redirect_cause_i <= 3'd3) ?
                    ex_redirect_cause_i : CAUSE_NOCOND;
   end

   // Jump triple: exception > execute redirect > interrupt; zeros when idle.
   always_comb begin
      jump_cause_o     = CAUSE_NONE;
      jump_from_addr_o = '0;
      jump_to_addr_o   = '0;
      if (exc_take) begin
         jump_cause_o     = CAUSE_EXC;
         jump_from_addr_o = exc_pc_i;
         jump_to_addr_o   = exc_vector_i;
      end else if (ex_take) begin
         jump_cause_o     = ex_cause;
         jump_from_addr_o = ex_redirect_from_i;
         jump_to_addr_o   = ex_redirect_to_i;
      end else if (irq_take) begin
         jump_cause_o     = CAUSE_IRQ;
         jump_from_addr_o = irq_ret_pc_i;
         jump_to_addr_o   = irq_vector_i;
      end
   end

   // Hold bus, flush, acknowledges. Hold is still driven during a redirect;
   // the PC gives its jump input priority over hold.
   always_comb begin
      hold_flag_o = 3'b000;
      if (rst_n) begin
         if (state == ST_HALTED || div_stall_i) hold_flag_o = 3'b111;
         else if (mem_stall_i)                  hold_flag_o = 3'b011;
      end
      flush_o      = rst_n && (issued || state == ST_FLUSH);
      irq_ack_o    = irq_take;
      dbg_halted_o = rst_n && (state == ST_HALTED);
   end

   // Control FSM with flush counter and interrupt pending latch.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_RUN;
         flush_cnt   <= 3'd0;
         irq_pending <= 1'b0;
      end else begin
         // Pending drops when the interrupt is disabled or taken.
         if (!irq_en_i)     irq_pending <= 1'b0;
         else if (irq_take) irq_pending <= 1'b0;
         else if (irq_req_i) irq_pending <= 1'b1;

         if (issued)                flush_cnt <= FLUSH_RELOAD;
         else if (flush_cnt != 3'd0) flush_cnt <= flush_cnt - 3'd1;

         case (state)
            ST_RUN: begin
               if (issued && MULTI_FLUSH) state <= ST_FLUSH;
               else if (dbg_halt_req_i)   state <= ST_DRAIN;
            end
            ST_FLUSH: begin
               // A redirect here reloads the counter and stays in FLUSH.
               if (!issued && flush_cnt <= 3'd1)
                  state <= dbg_halt_req_i ? ST_DRAIN : ST_RUN;
            end
            ST_DRAIN: begin
               if (issued && MULTI_FLUSH)               state <= ST_FLUSH;
               else if (!dbg_halt_req_i)                state <= ST_RUN;
               else if (!issued && !any_stall)          state <= ST_HALTED;
            end
            ST_HALTED: begin
               if (dbg_resume_req_i && !dbg_halt_req_i) state <= ST_RUN;
            end
            default: state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Bench for pc_flow_ctrl: directed scenarios followed by random traffic, all
// compared against a cycle reference model built from the block's rules.
module tb_pc_flow_ctrl;
  localparam int AW = 32;
  localparam int FC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ex_redirect_valid_i;
  logic [2:0]    ex_redirect_cause_i;
  logic [AW-1:0] ex_redirect_from_i, ex_redirect_to_i;
  logic          exc_valid_i;
  logic [AW-1:0] exc_pc_i, exc_vector_i;
  logic          irq_req_i, irq_en_i;
  logic [AW-1:0] irq_vector_i, irq_ret_pc_i;
  logic          mem_stall_i, div_stall_i, dbg_halt_req_i, dbg_resume_req_i;
  logic [2:0]    jump_cause_o;
  logic [AW-1:0] jump_from_addr_o, jump_to_addr_o;
  logic [2:0]    hold_flag_o;
  logic          flush_o, irq_ack_o, dbg_halted_o;

  int checks = 0;
  int failures = 0;

  // reference model state
  int m_bub = 0;      // bubble cycles still owed after the last redirect
  bit m_halted = 0;
  bit m_drain = 0;
  bit m_pend = 0;

  pc_flow_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC), .IRQ_ACK_W(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_redirect_valid_i(ex_redirect_valid_i), .ex_redirect_cause_i(ex_redirect_cause_i),
    .ex_redirect_from_i(ex_redirect_from_i), .ex_redirect_to_i(ex_redirect_to_i),
    .exc_valid_i(exc_valid_i), .exc_pc_i(exc_pc_i), .exc_vector_i(exc_vector_i),
    .irq_req_i(irq_req_i), .irq_en_i(irq_en_i), .irq_vector_i(irq_vector_i),
    .irq_ret_pc_i(irq_ret_pc_i), .mem_stall_i(mem_stall_i), .div_stall_i(div_stall_i),
    .dbg_halt_req_i(dbg_halt_req_i), .dbg_resume_req_i(dbg_resume_req_i),
    .jump_cause_o(jump_cause_o), .jump_from_addr_o(jump_from_addr_o),
    .jump_to_addr_o(jump_to_addr_o), .hold_flag_o(hold_flag_o), .flush_o(flush_o),
    .irq_ack_o(irq_ack_o), .dbg_halted_o(dbg_halted_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    ex_redirect_valid_i = 0; ex_redirect_cause_i = 0;
    ex_redirect_from_i = 0; ex_redirect_to_i = 0;
    exc_valid_i = 0; exc_pc_i = 0; exc_vector_i = 0;
    irq_req_i = 0; irq_en_i = 1; irq_vector_i = 32'h0000_0040; irq_ret_pc_i = 32'h0000_0500;
    mem_stall_i = 0; div_stall_i = 0; dbg_halt_req_i = 0; dbg_resume_req_i = 0;
  endtask

  task automatic settle();
    #3;
  endtask

  // Compare every output with the model for the current inputs, advance the
  // model over the coming edge, then move to just after that edge.
  task automatic finish_cycle();
    bit ok, in_run, take, issued, nh;
    int nb;
    logic [2:0] e_cause, e_hold;
    logic [AW-1:0] e_from, e_to;
    bit e_flush;
    e_cause = 0; e_from = 0; e_to = 0; e_hold = 0; e_flush = 0;
    take = 0; issued = 0;
    if (rst_n) begin
      ok = !m_halted;
      in_run = ok && !m_drain && m_bub == 0;
      take = in_run && !mem_stall_i && !div_stall_i && !exc_valid_i &&
             !ex_redirect_valid_i && irq_en_i && (m_pend || irq_req_i);
      if (ok && exc_valid_i) begin
        e_cause = 5; e_from = exc_pc_i; e_to = exc_vector_i;
      end else if (ok && ex_redirect_valid_i) begin
        e_cause = (ex_redirect_cause_i >= 1 && ex_redirect_cause_i <= 3) ? ex_redirect_cause_i : 3'd3;
        e_from = ex_redirect_from_i; e_to = ex_redirect_to_i;
      end else if (take) begin
        e_cause = 4; e_from = irq_ret_pc_i; e_to = irq_vector_i;
      end
      issued = (e_cause != 0);
      e_flush = issued || m_bub > 0;
      e_hold = (m_halted || div_stall_i) ? 3'b111 : (mem_stall_i ? 3'b011 : 3'b000);
    end
    chk("jump_cause", 64'(jump_cause_o), 64'(e_cause));
    chk("jump_from", 64'(jump_from_addr_o), 64'(e_from));
    chk("jump_to", 64'(jump_to_addr_o), 64'(e_to));
    chk("hold_flag", 64'(hold_flag_o), 64'(e_hold));
    chk("flush", 64'(flush_o), 64'(e_flush));
    chk("irq_ack", 64'(irq_ack_o), 64'(take));
    chk("dbg_halted", 64'(dbg_halted_o), 64'(rst_n && m_halted));
    if (!rst_n) begin
      m_bub = 0; m_halted = 0; m_drain = 0; m_pend = 0;
    end else begin
      nb = issued ? FC - 1 : (m_bub > 0 ? m_bub - 1 : 0);
      m_pend = irq_en_i ? (take ? 1'b0 : (m_pend | irq_req_i)) : 1'b0;
      nh = m_halted ? !(dbg_resume_req_i && !dbg_halt_req_i)
                    : (m_drain && dbg_halt_req_i && !issued && !mem_stall_i && !div_stall_i);
      m_drain = !m_halted && !nh && dbg_halt_req_i && nb == 0;
      m_halted = nh;
      m_bub = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    settle();
    finish_cycle();
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    @(posedge clk); #1;

    // reset with every input active
    ex_redirect_valid_i = 1; ex_redirect_cause_i = 1; exc_valid_i = 1; irq_req_i = 1;
    mem_stall_i = 1; div_stall_i = 1; dbg_halt_req_i = 1; dbg_resume_req_i = 1;
    exc_vector_i = 32'h80; ex_redirect_to_i = 32'h200;
    settle();
    chk("rst_cause", 64'(jump_cause_o), 64'd0);
    chk("rst_hold", 64'(hold_flag_o), 64'd0);
    chk("rst_flush", 64'(flush_o), 64'd0);
    chk("rst_ack", 64'(irq_ack_o), 64'd0);
    finish_cycle();
    cyc();
    idle_inputs(); rst_n = 1;
    settle();
    chk("idle_cause", 64'(jump_cause_o), 64'd0);
    finish_cycle();

    // execute redirect cause 1, 0x100 -> 0x200
    ex_redirect_valid_i = 1; ex_redirect_cause_i = 1;
    ex_redirect_from_i = 32'h100; ex_redirect_to_i = 32'h200;
    settle();
    chk("br_c0_cause", 64'(jump_cause_o), 64'd1);
    chk("br_c0_to", 64'(jump_to_addr_o), 64'h200);
    chk("br_c0_flush", 64'(flush_o), 64'd1);
    finish_cycle();
    idle_inputs();
    settle(); chk("br_c1_flush", 64'(flush_o), 64'd1); finish_cycle();
    settle(); chk("br_c2_flush", 64'(flush_o), 64'd0); finish_cycle();

    // exception beats execute redirect; concurrent irq stays pending
    exc_valid_i = 1; exc_pc_i = 32'h300; exc_vector_i = 32'h80;
    ex_redirect_valid_i = 1; ex_redirect_cause_i = 2; ex_redirect_to_i = 32'h444;
    irq_req_i = 1;
    settle();
    chk("exc_cause", 64'(jump_cause_o), 64'd5);
    chk("exc_to", 64'(jump_to_addr_o), 64'h80);
    finish_cycle();
    idle_inputs();
    settle(); chk("exc_flush_noack", 64'(irq_ack_o), 64'd0); finish_cycle();
    settle();
    chk("irq_after_flush_cause", 64'(jump_cause_o), 64'd4);
    chk("irq_after_flush_ack", 64'(irq_ack_o), 64'd1);
    finish_cycle();
    cyc(); cyc();

    // interrupt blocked by divider stall
    irq_req_i = 1; div_stall_i = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("div_hold", 64'(hold_flag_o), 64'h7);
      chk("div_noack", 64'(irq_ack_o), 64'd0);
      finish_cycle();
    end
    div_stall_i = 0;
    settle(); chk("div_drop_ack", 64'(irq_ack_o), 64'd1); finish_cycle();
    idle_inputs(); cyc(); cyc();

    // interrupt enable drops before the take
    irq_req_i = 1; div_stall_i = 1; cyc();
    irq_req_i = 0; irq_en_i = 0; cyc();
    irq_en_i = 1; div_stall_i = 0;
    settle(); chk("en_drop_noack", 64'(irq_ack_o), 64'd0); finish_cycle();

    // debug halt while memory stalls
    dbg_halt_req_i = 1; mem_stall_i = 1;
    cyc();
    settle(); chk("drain_hold", 64'(hold_flag_o), 64'h3); finish_cycle();
    mem_stall_i = 0; cyc();
    settle();
    chk("halted_flag", 64'(dbg_halted_o), 64'd1);
    chk("halted_hold", 64'(hold_flag_o), 64'h7);
    finish_cycle();
    dbg_resume_req_i = 1; cyc();           // ignored: halt still requested
    dbg_halt_req_i = 0; cyc();
    dbg_resume_req_i = 0;
    settle();
    chk("resumed_flag", 64'(dbg_halted_o), 64'd0);
    chk("resumed_hold", 64'(hold_flag_o), 64'd0);
    finish_cycle();

    // reset mid-flush
    exc_valid_i = 1; exc_vector_i = 32'h80; cyc();
    exc_valid_i = 0; rst_n = 0; cyc();
    rst_n = 1;
    settle(); chk("rst_mid_flush", 64'(flush_o), 64'd0); finish_cycle();

    // reset mid-halt with an interrupt pending
    irq_req_i = 1; div_stall_i = 1; cyc();
    irq_req_i = 0; div_stall_i = 0; dbg_halt_req_i = 1; irq_en_i = 0;
    cyc(); cyc(); cyc();
    irq_en_i = 1;
    irq_req_i = 1; cyc(); irq_req_i = 0;  // pending while halted
    rst_n = 0; cyc();
    rst_n = 1; dbg_halt_req_i = 0;
    settle();
    chk("rst_mid_halt", 64'(dbg_halted_o), 64'd0);
    chk("rst_clears_pending", 64'(irq_ack_o), 64'd0);
    finish_cycle();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(99, 0) >= 2);
      exc_valid_i = ($urandom_range(99, 0) < 8);
      exc_pc_i = $urandom; exc_vector_i = $urandom;
      ex_redirect_valid_i = ($urandom_range(99, 0) < 15);
      ex_redirect_cause_i = 3'($urandom_range(7, 0));
      ex_redirect_from_i = $urandom; ex_redirect_to_i = $urandom;
      irq_req_i = ($urandom_range(99, 0) < 30);
      irq_en_i = ($urandom_range(99, 0) < 85);
      irq_vector_i = $urandom; irq_ret_pc_i = $urandom;
      mem_stall_i = ($urandom_range(99, 0) < 25);
      div_stall_i = ($urandom_range(99, 0) < 12);
      if ($urandom_range(99, 0) < 8) dbg_halt_req_i = ~dbg_halt_req_i;
      dbg_resume_req_i = ($urandom_range(99, 0) < 25);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pc_flow_ctrl.md
Name: pc_flow_ctrl

Overview:
- Sequences the PC unit. Arbitrates redirect sources (execute-stage branch resolve, exception, interrupt) into one jump_cause/jump_from/jump_to triple.
- Generates the pipeline hold bus from memory/divider stalls and the debug halt handshake.
- Inserts post-redirect flush bubbles.
- Sits between execute/CSR/debug logic and the PC and fetch stages.

Parameters:
- ADDR_W, 32, instruction address width.
- FLUSH_CYCLES, 2, bubble cycles after any redirect (1..7).
- IRQ_ACK_W, 1, width of irq acknowledge pulse in cycles (fixed 1 in this revision).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- ex_redirect_valid_i  in  1  execute resolved a mispredict or unconditional jump.
- ex_redirect_cause_i  in  3  cause code from execute: 1 predict_no_but_yes, 2 predict_yes_but_no, 3 nocondition.
- ex_redirect_from_i  in  ADDR_W  address of the redirecting instruction.
- ex_redirect_to_i  in  ADDR_W  redirect target.
- exc_valid_i  in  1  synchronous exception.
- exc_pc_i  in  ADDR_W  faulting PC.
- exc_vector_i  in  ADDR_W  exception handler address.
- irq_req_i  in  1  level interrupt request.
- irq_en_i  in  1  global interrupt enable.
- irq_vector_i  in  ADDR_W  interrupt handler address.
- irq_ret_pc_i  in  ADDR_W  PC of the oldest uncommitted instruction.
- mem_stall_i  in  1  memory stage busy.
- div_stall_i  in  1  multicycle divider busy.
- dbg_halt_req_i  in  1  debug halt request (level).
- dbg_resume_req_i  in  1  debug resume (pulse).
- jump_cause_o  out  3  0 no, 1/2/3 as above, 4 interrupt, 5 exception.
- jump_from_addr_o  out  ADDR_W  redirect source address.
- jump_to_addr_o  out  ADDR_W  redirect target.
- hold_flag_o  out  3  000 none, 001 hold pc, 011 hold pc+if, 111 hold pc+if+id.
- flush_o  out  1  kill IF/ID contents this cycle.
- irq_ack_o  out  1  one-cycle interrupt accept pulse.
- dbg_halted_o  out  1  core halted acknowledge.

Behaviour:
- Reset (synchronous, rst_n low at clk edge):
  - State RUN; irq_pending=0; flush_cnt=0.
  - All outputs 0 / 000 (jump_cause_o 0, hold_flag_o 000, flush_o 0, irq_ack_o 0, dbg_halted_o 0).
  - Reset mid-flush or mid-halt aborts immediately.
- States:
  - RUN: normal.
  - FLUSH: bubbles, counting down.
  - DRAIN: halt requested, waiting for stalls to clear.
  - HALTED.
- Redirect arbitration (combinational, same cycle, any state except HALTED):
  - Priority: exception > ex_redirect > interrupt.
  - Exception: cause 5, from=exc_pc_i, to=exc_vector_i.
  - ex_redirect: cause=ex_redirect_cause_i, from/to passthrough.
  - Interrupt: cause 4, from=irq_ret_pc_i, to=irq_vector_i.
  - When no redirect: jump_cause_o=0; from/to outputs hold 0.
  - ex_redirect_cause_i values other than 1..3 are treated as 3.
- Interrupt:
  - irq_pending sets when irq_req_i&irq_en_i.
  - Interrupt is taken only in RUN, with mem_stall_i=0, div_stall_i=0, and no exception or ex_redirect that cycle.
  - On take: irq_ack_o=1 for exactly that cycle; irq_pending cleared at next edge.
  - A lost arbitration keeps irq_pending set.
  - irq_en_i falling clears irq_pending.
- Flush:
  - Any issued redirect sets flush_o=1 that cycle, loads flush_cnt=FLUSH_CYCLES-1, and enters FLUSH if FLUSH_CYCLES>1.
  - In FLUSH: flush_o=1; flush_cnt decrements each cycle; return to RUN when it reaches 0.
  - A new exception or ex_redirect in FLUSH is issued and reloads the counter.
  - Interrupts are not taken in FLUSH.
- Hold:
  - div_stall_i → 111.
  - else mem_stall_i → 011.
  - else 000.
  - A redirect in the same cycle overrides hold (the PC loads the target); hold_flag_o is still driven, and the PC's jump priority resolves it.
- Debug:
  - dbg_halt_req_i in RUN/FLUSH → DRAIN (a FLUSH in progress completes first, i.e. enter DRAIN only when flush_cnt==0).
  - DRAIN → HALTED when both stalls are 0.
  - HALTED: hold_flag_o=111, dbg_halted_o=1, no redirects or irq taken.
  - dbg_resume_req_i in HALTED → RUN next cycle; dbg_halted_o drops at the same edge.
  - Resume while dbg_halt_req_i is still high is ignored.
  - Exception during DRAIN is issued; DRAIN waits for its flush to finish.

Test Plan:
- Reset with all inputs active → every output 0 / 000, state RUN after release; first cycle with no requests shows jump_cause_o=0.
- ex_redirect cause 1, from 0x100 to 0x200, FLUSH_CYCLES=2:
  - cycle 0: jump_cause_o=1, to=0x200, flush_o=1.
  - cycle 1: flush_o=1.
  - cycle 2: flush_o=0.
- Same-cycle exception (vector 0x80) and ex_redirect → cause 5 to 0x80; a concurrent irq_req stays pending and is taken (cause 4, irq_ack_o=1) the first RUN cycle after the flush.
- irq_req with div_stall_i=1 for 3 cycles → hold_flag_o=111, irq_ack_o=0; the interrupt is taken the cycle the stall drops. Separately, irq_en_i dropped before the take → no ack.
- dbg_halt_req during mem_stall_i → DRAIN, hold_flag_o=011; stall clears → dbg_halted_o=1, hold_flag_o=111; resume pulse → dbg_halted_o=0, hold 000 next cycle.
- rst_n asserted mid-FLUSH and mid-HALTED → next cycle flush_o=0, dbg_halted_o=0, irq_pending cleared.
